// File: rtl/dll_lock_sequencer.sv
//
// dll_lock_sequencer
// ------------------
// Acquisition/tracking controller for the DLL phase-tracking datapath
// (PTC, clock divider, HLD, PD, SAR, decoder).
//
// Sequence:
//   IDLE -> CONFIG (latch Sel/M/N, hold SAR clear while the line settles)
//        -> SEARCH (time the SAR binary search in sample_ticks)
//        -> VERIFY (count PD COMP dithering)
//        -> LOCKED (watch for a run of equal COMP samples = loss of lock)
//   Failed verifies retry through CONFIG. After MAX_RETRY failures the
//   block parks in FAIL until start drops. A config change while active
//   forces reacquisition.
//
// Ports:
//   CLK_exit      reference clock, rising edge
//   rst           asynchronous active-high reset
//   start         level enable; low returns to IDLE
//   cfg_Sel/M/N   requested multiply configuration
//   COMP          PD comparator (synchronous to CLK_exit)
//   sample_tick   one-cycle strobe: COMP valid / SAR stepped
//   Sel_o/M_o/N_o registered configuration to the PTC
//   sar_clear     holds SAR/decoder in reset
//   pd_enable     PD enable
//   lock          high in LOCKED
//   lock_lost     one-cycle pulse on loss of lock
//   fail          high in FAIL
//   state         FSM state (IDLE=0 CONFIG=1 SEARCH=2 VERIFY=3 LOCKED=4 FAIL=5)
//   relock_count  saturating count of lock losses
//
// Handshake note: there is no valid/ready pair here. sample_tick is a
// qualifier strobe with no back-pressure; COMP is only consumed in a cycle
// where sample_tick is high and the FSM is in SEARCH, VERIFY or LOCKED.
`timescale 1ns/1ps
module dll_lock_sequencer #(
  parameter int SETTLE_CYC = 16,
  parameter int SAR_BITS   = 10,
  parameter int VERIFY_N   = 8,
  parameter int MIN_TOGGLE = 3,
  parameter int LOSS_RUN   = 6,
  parameter int MAX_RETRY  = 3
) (
  input  logic       CLK_exit,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cfg_Sel,
  input  logic [1:0] cfg_M,
  input  logic [2:0] cfg_N,
  input  logic       COMP,
  input  logic       sample_tick,
  output logic [1:0] Sel_o,
  output logic [1:0] M_o,
  output logic [2:0] N_o,
  output logic       sar_clear,
  output logic       pd_enable,
  output logic       lock,
  output logic       lock_lost,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int MAX_A   = (SETTLE_CYC > SAR_BITS) ? SETTLE_CYC : SAR_BITS;
  localparam int MAX_B   = (VERIFY_N > LOSS_RUN) ? VERIFY_N : LOSS_RUN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TOG_W   = $clog2(VERIFY_N + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_SEARCH = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  // cnt_q is shared: settle cycles (CONFIG), ticks (SEARCH/VERIFY),
  // equal-COMP run length (LOCKED). Cleared on every state change.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             prev_q, prev_d;
  logic [7:0]       relock_q, relock_d;
  logic             lost_q, lost_d;
  logic [1:0]       sel_q, m_q;
  logic [2:0]       n_q;

  logic             cfg_change;
  logic             active;
  logic             cfg_load;
  logic [TOG_W-1:0] tog_next;
  logic [CNT_W-1:0] run_next;
  logic [RTY_W-1:0] retry_inc;

  // State and datapath registers
  always_ff @(posedge CLK_exit or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tog_q    <= '0;
      retry_q  <= '0;
      prev_q   <= 1'b0;
      relock_q <= 8'd0;
      lost_q   <= 1'b0;
      sel_q    <= 2'd0;
      m_q      <= 2'd0;
      n_q      <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tog_q    <= tog_d;
      retry_q  <= retry_d;
      prev_q   <= prev_d;
      relock_q <= relock_d;
      lost_q   <= lost_d;
      if (cfg_load) begin
        sel_q <= cfg_Sel;
        m_q   <= cfg_M;
        n_q   <= cfg_N;
      end
    end
  end

  // Next-state logic. Priority: start low > config change > tick/counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    retry_d   = retry_q;
    prev_d    = prev_q;
    relock_d  = relock_q;
    lost_d    = 1'b0;
    tog_next  = tog_q;
    run_next  = cnt_q;
    retry_inc = retry_q + RTY_W'(1);

    cfg_change = (cfg_Sel != sel_q) || (cfg_M != m_q) || (cfg_N != n_q);
    active     = (state_q == S_SEARCH) || (state_q == S_VERIFY) ||
                 (state_q == S_LOCKED);

    if (!start) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else if (active && cfg_change) begin
      state_d = S_CONFIG;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CONFIG;

        S_CONFIG: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_SEARCH;
          else                                 cnt_d   = cnt_q + CNT_W'(1);
        end

        S_SEARCH: begin
          if (sample_tick) begin
            if (cnt_q == CNT_W'(SAR_BITS - 1)) state_d = S_VERIFY;
            else                               cnt_d   = cnt_q + CNT_W'(1);
          end
        end

        S_VERIFY: begin
          if (sample_tick) begin
            prev_d = COMP;
            // First verify tick only seeds the COMP reference.
            if ((cnt_q != '0) && (COMP != prev_q)) tog_next = tog_q + TOG_W'(1);
            if (cnt_q == CNT_W'(VERIFY_N - 1)) begin
              if (tog_next >= TOG_W'(MIN_TOGGLE)) begin
                state_d = S_LOCKED;
                retry_d = '0;
              end else begin
                retry_d = retry_inc;
                state_d = (retry_inc == RTY_W'(MAX_RETRY)) ? S_FAIL : S_CONFIG;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              tog_d = tog_next;
            end
          end
        end

        S_LOCKED: begin
          if (sample_tick) begin
            prev_d = COMP;
            // Run length of equal COMP samples; the first locked tick starts a run.
            if ((cnt_q == '0) || (COMP != prev_q)) run_next = CNT_W'(1);
            else                                   run_next = cnt_q + CNT_W'(1);
            if (run_next == CNT_W'(LOSS_RUN)) begin
              state_d  = S_CONFIG;
              lost_d   = 1'b1;
              relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            end else begin
              cnt_d = run_next;
            end
          end
        end

        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      tog_d = '0;
    end

    cfg_load = (state_d == S_CONFIG) && (state_q != S_CONFIG);
  end

  // Output decode from registered state
  always_comb begin
    sar_clear    = 1'b1;
    pd_enable    = 1'b0;
    lock         = 1'b0;
    fail         = 1'b0;
    case (state_q)
      S_SEARCH, S_VERIFY: begin
        sar_clear = 1'b0;
        pd_enable = 1'b1;
      end
      S_LOCKED: begin
        sar_clear = 1'b0;
        pd_enable = 1'b1;
        lock      = 1'b1;
      end
      S_FAIL:  fail = 1'b1;
      default: ;
    endcase
    state        = state_q;
    lock_lost    = lost_q;
    relock_count = relock_q;
    Sel_o        = sel_q;
    M_o          = m_q;
    N_o          = n_q;
  end

endmodule

// File: tb/tb_dll_lock_sequencer.sv
`timescale 1ns/1ps
module tb_dll_lock_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cfg_Sel;
  logic [1:0] cfg_M;
  logic [2:0] cfg_N;
  logic       COMP;
  logic       sample_tick;
  logic [1:0] Sel_o;
  logic [1:0] M_o;
  logic [2:0] N_o;
  logic       sar_clear, pd_enable, lock, lock_lost, fail;
  logic [2:0] state;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;
  int vfail_cnt = 0;
  int exp_relock;

  always #5 clk = ~clk;

  dll_lock_sequencer dut (
    .CLK_exit    (clk),
    .rst         (rst),
    .start       (start),
    .cfg_Sel     (cfg_Sel),
    .cfg_M       (cfg_M),
    .cfg_N       (cfg_N),
    .COMP        (COMP),
    .sample_tick (sample_tick),
    .Sel_o       (Sel_o),
    .M_o         (M_o),
    .N_o         (N_o),
    .sar_clear   (sar_clear),
    .pd_enable   (pd_enable),
    .lock        (lock),
    .lock_lost   (lock_lost),
    .fail        (fail),
    .state       (state),
    .relock_count(relock_count)
  );

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample_tick with the given COMP, then idle to the next tick slot
  // (tick period 4 cycles). Returns on a negedge.
  task automatic do_tick(input logic c);
    COMP = c;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Tick (alternating / stuck-0 / stuck-1 COMP) until state reaches target,
  // bounded by max_ticks; an expired bound shows up as a failed check.
  task automatic tick_until(input logic [2:0] target, input int mode,
                            input int max_ticks, input string tag);
    int n;
    logic c;
    logic [2:0] prev_st;
    n = 0;
    c = 1'b0;
    while (state !== target && n < max_ticks) begin
      if (mode == 0)      c = ~c;
      else if (mode == 1) c = 1'b0;
      else                c = 1'b1;
      prev_st = state;
      do_tick(c);
      if (prev_st == 3'd3 && state == 3'd1) vfail_cnt++;
      n++;
    end
    chk(tag, state, target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; cfg_Sel = 2'd0; cfg_M = 2'd0; cfg_N = 3'd0;
    COMP = 1'b0; sample_tick = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_state", state, 0);
    chk("rst_sar_clear", sar_clear, 1);
    chk("rst_pd_enable", pd_enable, 0);
    chk("rst_lock", lock, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_fail", fail, 0);
    chk("rst_relock", relock_count, 0);
    chk("rst_cfg", {Sel_o, M_o, N_o}, 0);

    // Basic lock: cfg (2,1,3)
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", state, 0);
    cfg_Sel = 2'd2; cfg_M = 2'd1; cfg_N = 3'd3; start = 1'b1;
    @(negedge clk);
    chk("cfg_enter", state, 1);
    chk("cfg_sar_clear", sar_clear, 1);
    chk("cfg_pd_enable", pd_enable, 0);
    chk("cfg_latched", {Sel_o, M_o, N_o}, {2'd2, 2'd1, 3'd3});
    // Ticks during CONFIG must not shorten the 16-cycle settle window
    for (int i = 0; i < 15; i++) begin
      sample_tick = (i % 4 == 0);
      @(negedge clk);
      chk("cfg_hold", state, 1);
      chk("cfg_hold_clear", sar_clear, 1);
    end
    sample_tick = 1'b0;
    @(negedge clk);
    chk("search_enter", state, 2);
    chk("search_sar_clear", sar_clear, 0);
    chk("search_pd_enable", pd_enable, 1);
    for (int k = 0; k < 9; k++) do_tick(k[0]);
    chk("search_9_ticks", state, 2);
    do_tick(1'b0);
    chk("verify_enter", state, 3);
    for (int k = 0; k < 7; k++) do_tick(k[0]);
    chk("verify_7_ticks", state, 3);
    do_tick(1'b1);
    chk("locked_enter", state, 4);
    chk("locked_lock", lock, 1);
    chk("locked_cfg", {Sel_o, M_o, N_o}, {2'd2, 2'd1, 3'd3});
    chk("locked_relock", relock_count, 0);

    // Loss of lock: COMP held at 1 for 6 ticks
    for (int k = 0; k < 5; k++) do_tick(1'b1);
    chk("loss_5_ticks", state, 4);
    COMP = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("loss_state", state, 1);
    chk("loss_pulse", lock_lost, 1);
    chk("loss_lock", lock, 0);
    chk("loss_relock", relock_count, 1);
    @(negedge clk);
    chk("loss_pulse_end", lock_lost, 0);
    tick_until(3'd4, 0, 40, "relock");
    chk("relock_lock", lock, 1);

    // Config change coinciding with what would be the loss tick: CONFIG wins,
    // no lock_lost, relock_count unchanged.
    for (int k = 0; k < 5; k++) do_tick(1'b1);
    cfg_N = 3'd5; COMP = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("cfgchg_state", state, 1);
    chk("cfgchg_lock", lock, 0);
    chk("cfgchg_no_pulse", lock_lost, 0);
    chk("cfgchg_N", N_o, 5);
    chk("cfgchg_relock", relock_count, 1);
    tick_until(3'd4, 0, 40, "relock_n5");
    chk("relock_n5_N", N_o, 5);

    // start drops mid-VERIFY
    start = 1'b0;
    @(negedge clk);
    chk("stop_locked", state, 0);
    start = 1'b1;
    tick_until(3'd3, 0, 40, "to_verify");
    for (int k = 0; k < 3; k++) do_tick(k[0]);
    chk("verify_mid", state, 3);
    start = 1'b0;
    @(negedge clk);
    chk("stop_verify", state, 0);
    chk("stop_sar_clear", sar_clear, 1);
    chk("stop_pd_enable", pd_enable, 0);
    chk("stop_relock_kept", relock_count, 1);

    // Retry exhaustion: COMP stuck 0
    start = 1'b1;
    vfail_cnt = 0;
    tick_until(3'd5, 1, 100, "fail_reach");
    chk("fail_retries", vfail_cnt, 2);
    chk("fail_flag", fail, 1);
    chk("fail_sar_clear", sar_clear, 1);
    chk("fail_pd_enable", pd_enable, 0);
    chk("fail_lock", lock, 0);
    do_tick(1'b1);
    do_tick(1'b0);
    chk("fail_sticky", state, 5);
    start = 1'b0;
    @(negedge clk);
    chk("fail_exit", state, 0);
    chk("fail_clear", fail, 0);

    // Saturation: 256 loss events on top of the existing count of 1
    start = 1'b1;
    exp_relock = 1;
    for (int i = 0; i < 256; i++) begin
      tick_until(3'd4, 0, 40, "sat_lock");
      for (int k = 0; k < 6; k++) do_tick(1'b1);
      exp_relock = (exp_relock == 255) ? 255 : exp_relock + 1;
      chk("sat_count", relock_count, exp_relock);
    end
    chk("sat_final", relock_count, 255);

    // Asynchronous reset mid-SEARCH
    tick_until(3'd2, 0, 20, "to_search");
    for (int k = 0; k < 3; k++) do_tick(1'b0);
    chk("search_mid", state, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_relock", relock_count, 0);
    chk("arst_sar_clear", sar_clear, 1);
    chk("arst_pd_enable", pd_enable, 0);
    chk("arst_cfg", {Sel_o, M_o, N_o}, 0);
    chk("arst_lock_lost", lock_lost, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dll_lock_sequencer.md
Name: dll_lock_sequencer

Overview:
- Acquisition/tracking controller for the phase-tracking datapath: PTC, clock divider, HLD, PD, SAR and decoder.
- Applies the multiply configuration (Sel/M/N) and holds the SAR in clear while the delay line settles.
- Times the 10-step SAR binary search, then verifies lock from PD COMP dithering.
- Monitors for lock loss and relocks automatically; a configuration change also forces reacquisition.

Parameters:
- SETTLE_CYC, 16: CLK_exit cycles sar_clear is held in CONFIG.
- SAR_BITS, 10: sample_ticks in one SAR search.
- VERIFY_N, 8: sample_ticks observed in VERIFY.
- MIN_TOGGLE, 3: COMP toggles needed in VERIFY to declare lock.
- LOSS_RUN, 6: consecutive equal COMP samples in LOCKED that signal loss.
- MAX_RETRY, 3: failed VERIFY attempts before FAIL.

Ports:
- CLK_exit  in  1  reference clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; high enables acquisition, low returns to IDLE.
- cfg_Sel  in  2  requested Sel.
- cfg_M  in  2  requested M.
- cfg_N  in  3  requested N.
- COMP  in  1  PD comparator result, already synchronous to CLK_exit.
- sample_tick  in  1  one-cycle strobe: COMP valid / SAR stepped (clk4 edge, pre-synchronized).
- Sel_o  out  2  registered Sel to PTC.
- M_o  out  2  registered M to PTC.
- N_o  out  3  registered N to PTC.
- sar_clear  out  1  high holds SAR/decoder in reset (drives rst_n inverted).
- pd_enable  out  1  PD enable.
- lock  out  1  high only in LOCKED.
- lock_lost  out  1  one-cycle pulse on loss of lock.
- fail  out  1  high in FAIL.
- state  out  3  IDLE=0, CONFIG=1, SEARCH=2, VERIFY=3, LOCKED=4, FAIL=5.
- relock_count  out  8  saturating count of lock losses.

Behaviour:
- Reset values:
  - state=IDLE; Sel_o/M_o/N_o=0; sar_clear=1; pd_enable=0; lock=0; lock_lost=0; fail=0; relock_count=0.
  - Internal counters and retry counter = 0.
- All outputs are registered; state decode is visible the cycle after the transition.
- Configuration capture:
  - cfg_* are latched into Sel_o/M_o/N_o on every entry to CONFIG.
  - cfg_* != *_o while in SEARCH, VERIFY or LOCKED -> go to CONFIG next cycle.
  - A config change clears the retry counter and does not pulse lock_lost.
- IDLE:
  - sar_clear=1, pd_enable=0.
  - start=1 -> CONFIG.
- CONFIG:
  - sar_clear=1, pd_enable=0.
  - Cycle counter counts CLK_exit cycles, ignoring sample_tick.
  - After SETTLE_CYC cycles -> SEARCH.
- SEARCH:
  - sar_clear=0, pd_enable=1.
  - Count sample_ticks; on the SAR_BITS-th tick -> VERIFY.
- VERIFY:
  - Count sample_ticks and count ticks where COMP differs from the previous sampled COMP; the first tick only sets the reference.
  - On the VERIFY_N-th tick, toggles>=MIN_TOGGLE -> LOCKED; retry counter is cleared.
  - On the VERIFY_N-th tick, otherwise retry+1; if the result equals MAX_RETRY -> FAIL, else CONFIG.
- LOCKED:
  - lock=1.
  - run counter = consecutive ticks with equal COMP; reset to 1 on a toggle.
  - run reaches LOSS_RUN -> lock_lost pulse in the same cycle as the exit, relock_count+1 (saturates at 255) -> CONFIG.
- FAIL:
  - fail=1, sar_clear=1, pd_enable=0.
  - Stays until start drops; start low -> IDLE.
- start=0 in any state -> IDLE next cycle; counters are cleared and relock_count is kept.
- Priority when events coincide: rst > start=0 > config change > counter/tick event.
- sample_tick in IDLE, CONFIG or FAIL is ignored.
- rst mid-operation: immediate asynchronous return to all reset values, including relock_count.

Test Plan:
- Basic lock: rst pulse, start=1, cfg=(2,1,3), COMP alternating per tick, tick every 4 cycles.
  - CONFIG for 16 cycles with sar_clear=1.
  - Then SEARCH for 10 ticks, then VERIFY.
  - LOCKED after the 8th verify tick; lock=1; Sel_o=2, M_o=1, N_o=3.
- Loss of lock: in LOCKED, hold COMP=1 for 6 ticks.
  - lock_lost pulses for exactly 1 cycle, relock_count=1, state=CONFIG.
  - Alternating COMP afterwards relocks.
- Retry exhaustion: COMP stuck 0 through every VERIFY.
  - Three CONFIG->SEARCH->VERIFY passes, then state=FAIL, fail=1, sar_clear=1.
  - start=0 -> IDLE.
- Config change: while LOCKED, change cfg_N 3->5.
  - Next cycle state=CONFIG, lock=0, no lock_lost pulse, N_o=5, relock_count unchanged.
- Saturation: force 256 loss events.
  - relock_count stays 255.
  - rst asserted mid-SEARCH gives all reset values and relock_count=0.
- Edge cases:
  - start drops mid-VERIFY -> IDLE next cycle.
  - sample_tick in the same cycle as a config change -> CONFIG wins.
  - Ticks during CONFIG do not shorten the settle window.
